// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and defaults for the UART transmit scheduler family.
// Pure declarations: no logic, no latency, no flow control.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  localparam int DEF_N_REQ         = 4;
  localparam int DEF_CLKS_PER_BIT  = 868;
  localparam int DEF_TIMEOUT_TICKS = 4;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester and transmitter side signals of the scheduler, grouped as one bundle.
// slave = scheduler view; master = requesters plus transmitter view.
interface uart_tx_scheduler_if
  import uart_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) ();
  localparam int IDX_W = $clog2(N_REQ);

  logic                 i_ENABLE;
  logic [N_REQ-1:0]     i_REQ_VALID;
  logic [8*N_REQ-1:0]   i_REQ_DATA;
  logic [N_REQ-1:0]     o_REQ_ACK;
  logic                 i_TX_BUSY;
  logic                 o_TX_ENABLE;
  logic [7:0]           o_TX_DATA;
  logic                 o_CLK_ENABLE;
  logic [IDX_W-1:0]     o_GRANT_IDX;
  logic                 o_ACTIVE;
  logic                 o_ERROR;

  modport slave (
    input  i_ENABLE, i_REQ_VALID, i_REQ_DATA, i_TX_BUSY,
    output o_REQ_ACK, o_TX_ENABLE, o_TX_DATA, o_CLK_ENABLE,
           o_GRANT_IDX, o_ACTIVE, o_ERROR
  );

  modport master (
    output i_ENABLE, i_REQ_VALID, i_REQ_DATA, i_TX_BUSY,
    input  o_REQ_ACK, o_TX_ENABLE, o_TX_DATA, o_CLK_ENABLE,
           o_GRANT_IDX, o_ACTIVE, o_ERROR
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Free-running baud tick: one-cycle registered pulse every CLKS_PER_BIT clocks.
// Tick lands on the cycle the counter sits at CLKS_PER_BIT-1; no backpressure.
module uart_baud_gen
  import uart_sched_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic i_CLK,
  input  logic i_RESET_N,
  output logic o_CLK_ENABLE
);
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt;

  // Tick is registered one count early so it coincides with cnt == CLKS_PER_BIT-1.
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      cnt          <= '0;
      o_CLK_ENABLE <= 1'b0;
    end else begin
      cnt          <= (cnt == CW'(CLKS_PER_BIT - 1)) ? '0 : cnt + CW'(1);
      o_CLK_ENABLE <= (cnt == CW'(CLKS_PER_BIT - 2));
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin share of one uart_transmitter; grant one cycle after valid, abort after TIMEOUT_TICKS.
// Requesters hold valid/data until their one-cycle ack; i_TX_BUSY stalls all new grants.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int N_REQ         = DEF_N_REQ,
  parameter int CLKS_PER_BIT  = DEF_CLKS_PER_BIT,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
  input logic                i_CLK,
  input logic                i_RESET_N,
  uart_tx_scheduler_if.slave bus
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int TW    = $clog2(TIMEOUT_TICKS + 1);

  state_t            state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  grant_idx;
  logic [TW-1:0]     tick_cnt;
  logic              tx_en;
  logic [7:0]        tx_dat;
  logic              active;
  logic              err;
  logic [N_REQ-1:0]  ack;
  logic              clk_en;
  logic [IDX_W-1:0]  pick;

  // Search starts just after the last served (or aborted) requester.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] vld,
                                               input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] win;
    logic             found;
    idx   = last;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + IDX_W'(1);
      if (!found && vld[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud_gen (
    .i_CLK        (i_CLK),
    .i_RESET_N    (i_RESET_N),
    .o_CLK_ENABLE (clk_en)
  );

  assign pick = rr_pick(bus.i_REQ_VALID, ptr);

  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state     <= S_IDLE;
      ptr       <= IDX_W'(N_REQ - 1);
      grant_idx <= '0;
      tick_cnt  <= '0;
      tx_en     <= 1'b0;
      tx_dat    <= '0;
      active    <= 1'b0;
      err       <= 1'b0;
      ack       <= '0;
    end else begin
      ack <= '0;
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.i_ENABLE && !bus.i_TX_BUSY && (|bus.i_REQ_VALID)) begin
            grant_idx <= pick;
            tx_dat    <= bus.i_REQ_DATA[{pick, 3'b000} +: 8];
            tx_en     <= 1'b1;
            active    <= 1'b1;
            tick_cnt  <= '0;
            state     <= S_GRANT;
          end
        end
        S_GRANT: begin
          // Busy beats a timeout landing on the same edge.
          if (bus.i_TX_BUSY) begin
            ack[grant_idx] <= 1'b1;
            tx_en          <= 1'b0;
            ptr            <= grant_idx;
            state          <= S_BUSY;
          end else if (clk_en) begin
            tick_cnt <= tick_cnt + TW'(1);
            if (tick_cnt == TW'(TIMEOUT_TICKS - 1)) begin
              tx_en  <= 1'b0;
              err    <= 1'b1;
              active <= 1'b0;
              ptr    <= grant_idx;
              state  <= S_IDLE;
            end
          end
        end
        S_BUSY: begin
          if (!bus.i_TX_BUSY) begin
            active <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_REQ_ACK    = ack;
  assign bus.o_TX_ENABLE  = tx_en;
  assign bus.o_TX_DATA    = tx_dat;
  assign bus.o_CLK_ENABLE = clk_en;
  assign bus.o_GRANT_IDX  = grant_idx;
  assign bus.o_ACTIVE     = active;
  assign bus.o_ERROR      = err;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized bench: transaction-level requester/transmitter model with a
// round-robin scoreboard; directed phases cover reset, ordering, timeout, enable.
module tb_uart_tx_scheduler;
  localparam int N   = 4;
  localparam int CPB = 4;
  localparam int TO  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic tick5;

  uart_tx_scheduler_if #(.N_REQ(N)) bus ();

  uart_tx_scheduler #(.N_REQ(N), .CLKS_PER_BIT(CPB), .TIMEOUT_TICKS(TO)) dut (
    .i_CLK     (clk),
    .i_RESET_N (rst_n),
    .bus       (bus)
  );

  uart_baud_gen #(.CLKS_PER_BIT(5)) u_baud5 (
    .i_CLK        (clk),
    .i_RESET_N    (rst_n),
    .o_CLK_ENABLE (tick5)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] q [N][$];
  int         m_ptr, m_idx, m_ticks, n_edges, n_err, n_push;
  logic [7:0] m_dat;
  bit         m_grant, m_busyph;
  logic [N-1:0] p_valid;
  bit         p_en, p_busy, p_clk_en;
  bit         busy_drv, dead, dead_next;
  int         busy_cnt, busy_dly;
  bit         rand_dead, withdraw, refill, rand_en, en_drv;
  int         glog[$];
  int         alog[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic int rr_next(input logic [N-1:0] v, input int last);
    logic [N-1:0] sh;
    int j;
    for (int k = 1; k <= N; k++) begin
      j  = (last + k) % N;
      sh = v >> j;
      if (sh[0]) return j;
    end
    return -1;
  endfunction

  task automatic drive_inputs();
    logic vi;
    for (int i = 0; i < N; i++) begin
      vi = (q[i].size() > 0);
      if (withdraw && m_grant && i == m_idx && $urandom_range(0, 1) == 1) vi = 1'b0;
      bus.i_REQ_VALID[i] = vi;
      if (q[i].size() > 0) bus.i_REQ_DATA[8*i +: 8] = q[i][0];
      else                 bus.i_REQ_DATA[8*i +: 8] = 8'h00;
    end
    bus.i_ENABLE  = en_drv;
    bus.i_TX_BUSY = busy_drv;
    p_valid = bus.i_REQ_VALID;
    p_en    = en_drv;
    p_busy  = busy_drv;
  endtask

  task automatic model_reset();
    m_ptr = N - 1; m_idx = 0; m_dat = 8'h00; m_ticks = 0;
    m_grant = 0; m_busyph = 0; n_edges = 0;
    p_clk_en = 0; busy_drv = 0; busy_cnt = 0; busy_dly = 0; dead = 0;
    for (int i = 0; i < N; i++) q[i].delete();
    drive_inputs();
  endtask

  task automatic step();
    bit exp_grant, exp_ack, exp_err;
    int w;
    @(negedge clk);
    n_edges++;
    chk("baud4", bus.o_CLK_ENABLE, (n_edges % CPB) == CPB - 1);
    chk("baud5", tick5, (n_edges % 5) == 4);
    exp_grant = !m_grant && !m_busyph && p_en && !p_busy && (p_valid != 0);
    exp_ack   = m_grant && p_busy;
    exp_err   = m_grant && !p_busy && p_clk_en && (m_ticks + 1 == TO);
    chk("tx_enable", bus.o_TX_ENABLE, exp_grant || (m_grant && !exp_ack && !exp_err));
    chk("req_ack", bus.o_REQ_ACK, exp_ack ? (1 << m_idx) : 0);
    chk("error", bus.o_ERROR, exp_err);
    if (m_grant) begin
      if (exp_ack) begin
        m_grant = 0; m_busyph = 1; m_ptr = m_idx;
        alog.push_back(m_idx);
        void'(q[m_idx].pop_front());
      end else if (exp_err) begin
        m_grant = 0; m_ptr = m_idx; n_err++;
      end else if (p_clk_en) begin
        m_ticks++;
      end
    end else if (m_busyph) begin
      if (!p_busy) m_busyph = 0;
    end else if (exp_grant) begin
      w = rr_next(p_valid, m_ptr);
      m_idx = w; m_dat = q[w][0]; m_grant = 1; m_ticks = 0;
      glog.push_back(w);
      dead      = dead_next || (rand_dead && $urandom_range(0, 7) == 0);
      dead_next = 0;
      busy_dly  = $urandom_range(0, 2);
    end
    chk("active", bus.o_ACTIVE, m_grant || m_busyph);
    chk("grant_idx", bus.o_GRANT_IDX, m_idx);
    if (m_grant) chk("tx_data", bus.o_TX_DATA, m_dat);
    p_clk_en = bus.o_CLK_ENABLE;
    // Transmitter model: busy follows enable after a short delay, then holds for a frame.
    if (busy_drv) begin
      if (busy_cnt == 0) busy_drv = 0;
      else busy_cnt--;
    end else if (bus.o_TX_ENABLE && !dead) begin
      if (busy_dly == 0) begin
        busy_drv = 1;
        busy_cnt = $urandom_range(2, 10);
      end else busy_dly--;
    end
    if (refill)
      for (int i = 0; i < N; i++)
        if (q[i].size() < 2 && $urandom_range(0, 9) == 0) begin
          q[i].push_back(8'($urandom));
          n_push++;
        end
    if (rand_en) en_drv = ($urandom_range(0, 19) != 0);
    drive_inputs();
  endtask

  task automatic wait_phase(input bit busy_phase, input int max, input string tag);
    int k = 0;
    while (!(busy_phase ? m_busyph : m_grant) && k < max) begin
      step();
      k++;
    end
    chk(tag, busy_phase ? m_busyph : m_grant, 1);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_tx_enable"}, bus.o_TX_ENABLE, 0);
    chk({tag, "_active"}, bus.o_ACTIVE, 0);
    chk({tag, "_clk_enable"}, bus.o_CLK_ENABLE, 0);
    chk({tag, "_ack"}, bus.o_REQ_ACK, 0);
    chk({tag, "_error"}, bus.o_ERROR, 0);
  endtask

  task automatic reset_release();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int ord [5] = '{0, 1, 2, 3, 0};
    en_drv = 1; rand_dead = 0; withdraw = 0; refill = 0; rand_en = 0;
    dead_next = 0; n_err = 0; n_push = 0;
    model_reset();
    #1;
    check_cleared("reset");
    chk("reset_grant_idx", bus.o_GRANT_IDX, 0);
    chk("reset_tx_data", bus.o_TX_DATA, 0);
    reset_release();

    // Single requester, byte 0xA5.
    q[0].push_back(8'hA5);
    drive_inputs();
    repeat (60) step();
    chk("p1_grants", glog.size(), 1);
    chk("p1_acks", alog.size(), 1);
    chk("p1_ack_idx", alog.size() > 0 ? alog[0] : -1, 0);

    // All four requesters valid, two bytes each: rotation starts at 0.
    reset_release();
    glog.delete(); alog.delete();
    for (int i = 0; i < N; i++) begin
      q[i].push_back(8'(8'h10 + i));
      q[i].push_back(8'(8'h10 + i));
    end
    drive_inputs();
    repeat (250) step();
    for (int k = 0; k < 5; k++) begin
      chk("p2_grant_order", glog.size() > k ? glog[k] : -1, ord[k]);
      chk("p2_ack_order", alog.size() > k ? alog[k] : -1, ord[k]);
    end

    // Dead transmitter on the first grant: timeout, no ack, requester 2 goes next.
    glog.delete(); alog.delete(); n_err = 0;
    dead_next = 1;
    q[0].push_back(8'h77);
    q[2].push_back(8'h88);
    drive_inputs();
    repeat (150) step();
    chk("p3_errors", n_err, 1);
    chk("p3_grants", glog.size(), 3);
    chk("p3_second_grant", glog.size() > 1 ? glog[1] : -1, 2);
    chk("p3_first_ack", alog.size() > 0 ? alog[0] : -1, 2);

    // Enable dropped while busy: in-flight byte completes, nothing new until re-enabled.
    glog.delete(); alog.delete();
    q[1].push_back(8'h31);
    q[1].push_back(8'h32);
    drive_inputs();
    wait_phase(1, 100, "p4_reach_busy");
    en_drv = 0;
    drive_inputs();
    repeat (60) step();
    chk("p4_grants_disabled", glog.size(), 1);
    chk("p4_acks_disabled", alog.size(), 1);
    en_drv = 1;
    drive_inputs();
    repeat (60) step();
    chk("p4_grants_enabled", glog.size(), 2);
    chk("p4_acks_enabled", alog.size(), 2);

    // Asynchronous reset in the middle of a grant.
    for (int i = 0; i < N; i++) q[i].push_back(8'(8'hC0 + i));
    drive_inputs();
    repeat (3) step();
    wait_phase(0, 100, "p5_reach_grant");
    #2 rst_n = 1'b0;
    #1 check_cleared("async_reset");
    model_reset();
    repeat (2) @(negedge clk);
    glog.delete(); alog.delete();
    for (int i = 0; i < N; i++) q[i].push_back(8'(8'hD0 + i));
    drive_inputs();
    rst_n = 1'b1;
    repeat (80) step();
    chk("p5_first_winner", glog.size() > 0 ? glog[0] : -1, 0);

    // Random traffic, enable toggling, occasional dead transmitter, valid withdrawal.
    repeat (200) step();
    glog.delete(); alog.delete(); n_push = 0;
    for (int i = 0; i < N; i++) n_push -= q[i].size();
    rand_dead = 1; withdraw = 1; refill = 1; rand_en = 1;
    repeat (4000) step();
    rand_dead = 0; refill = 0; rand_en = 0; en_drv = 1;
    repeat (300) step();
    chk("p6_all_acked", alog.size(), n_push);
    chk("p6_end_active", bus.o_ACTIVE, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one uart_transmitter between N_REQ byte producers using round-robin arbitration.
- Generates the transmitter's baud-rate clock-enable tick.
- Sequences the transmitter's enable/data/busy handshake and times out if the transmitter never accepts a byte.
- Sits between requester logic (command/status formatters) and the uart_transmitter instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
CLKS_PER_BIT, 868, system clocks per baud tick (>=2)
TIMEOUT_TICKS, 4, baud ticks allowed in S_GRANT before abort (>=3)

Ports:
i_CLK  in  1  system clock, rising edge
i_RESET_N  in  1  asynchronous active-low reset
i_ENABLE  in  1  global enable; low blocks new grants only
i_REQ_VALID  in  N_REQ  per-requester byte valid
i_REQ_DATA  in  8*N_REQ  byte of requester i at [8i+7:8i]
o_REQ_ACK  out  N_REQ  one-cycle pulse: byte accepted by transmitter
i_TX_BUSY  in  1  transmitter o_TX_BUSY
o_TX_ENABLE  out  1  to transmitter i_TX_ENABLE
o_TX_DATA  out  8  to transmitter i_DATA_IN
o_CLK_ENABLE  out  1  baud tick to transmitter i_CLK_ENABLE
o_GRANT_IDX  out  clog2(N_REQ)  index of current/last grant
o_ACTIVE  out  1  high in S_GRANT or S_BUSY
o_ERROR  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset is asynchronous and active-low. Reset values: all outputs 0, state S_IDLE, baud counter 0, RR pointer N_REQ-1 (so requester 0 has first priority), tick counter 0.
- Baud generator:
  - Free-running counter 0..CLKS_PER_BIT-1, wraps to 0.
  - o_CLK_ENABLE=1 for exactly the cycle where counter==CLKS_PER_BIT-1.
  - Runs regardless of state.
- All outputs are registered.
- S_IDLE:
  - Grant when i_ENABLE=1, i_TX_BUSY=0 and any i_REQ_VALID bit is set.
  - Winner: first set bit searching ptr+1, ptr+2, ... modulo N_REQ.
  - Next cycle: o_TX_ENABLE=1, o_TX_DATA=captured byte, o_GRANT_IDX=winner, o_ACTIVE=1, tick counter cleared; go to S_GRANT. Latency from valid to o_TX_ENABLE is 1 cycle.
- S_GRANT:
  - Hold o_TX_ENABLE and o_TX_DATA stable.
  - On i_TX_BUSY=1: pulse o_REQ_ACK[winner] 1 cycle, o_TX_ENABLE=0, ptr=winner; go to S_BUSY.
  - Each o_CLK_ENABLE tick increments the tick counter. On reaching TIMEOUT_TICKS without busy: o_TX_ENABLE=0, o_ERROR pulse, no ack, ptr=winner (aborted requester loses priority); go to S_IDLE.
  - Busy and timeout in the same cycle: busy wins.
- S_BUSY:
  - o_TX_ENABLE=0. On i_TX_BUSY=0 go to S_IDLE and clear o_ACTIVE. A new grant is possible the following cycle.
- Requester rules:
  - Hold valid and data until ack.
  - The cycle after ack, either deassert valid or present the next byte.
  - Valid withdrawn during S_GRANT is ignored: the captured byte is still sent and acked.
- i_ENABLE falling mid-transfer: the in-flight byte completes normally.
- Reset asserted mid-transfer: outputs clear immediately; the transmitter is reset by its own reset path.
- Back-to-back bytes from one requester are fair: other pending requesters are served in between.

Decomposition:
- Package uart_sched_pkg: state encodings S_IDLE=2'd0, S_GRANT=2'd1, S_BUSY=2'd2; defaults for CLKS_PER_BIT and TIMEOUT_TICKS.
- Sub-module uart_baud_gen (counter and tick, parameter CLKS_PER_BIT). Reused by the future receiver scheduler.
- Round-robin select: function inside the scheduler.

Test Plan:
- Single requester, CLKS_PER_BIT=4, valid[0]=1 with data 0xA5 -> o_TX_ENABLE rises 1 cycle later with o_TX_DATA=0xA5; ack[0] pulses once when busy rises; serial line shows start bit, 1,0,1,0,0,1,0,1, stop bit.
- All four requesters valid continuously, data 0x10..0x13 -> grant order 0,1,2,3,0 and ack order identical; no grant while i_TX_BUSY=1.
- Transmitter busy forced to 0, TIMEOUT_TICKS=4 -> o_ERROR pulses after the 4th tick in S_GRANT; no ack; next grant goes to requester ptr+1.
- Drop i_ENABLE while in S_BUSY -> current byte completes and acks; no new grant until i_ENABLE=1 again.
- Assert i_RESET_N=0 mid-S_GRANT -> o_TX_ENABLE, o_ACTIVE, o_CLK_ENABLE become 0 asynchronously; after release, requester 0 wins first.
- Baud check, CLKS_PER_BIT=5 -> o_CLK_ENABLE high exactly 1 of every 5 cycles, first pulse on cycle 5 after reset release.
